// File: rtl/bank_readout_serializer.sv
// bank_readout_serializer: snapshots NBANKS parallel banks on START and streams them out one per valid/ready transfer.
// Ports: CLK/RST (async, active-high) clock and reset; START begins a readout (sampled in IDLE only);
//        BANK_IN flattened banks, bank i at [i*WIDTH +: WIDTH]; OUT_DATA/OUT_IDX/OUT_VALID with OUT_READY
//        form the output stream; BUSY is high in SEND and DONE; DONE pulses one cycle after the last bank.
// Build option CHANGE_FILTER_EN: keep a per-bank history of the last transferred value and skip
//        banks that have not changed since their previous transfer.
module bank_readout_serializer #(
    parameter int WIDTH  = 5,
    parameter int NBANKS = 5,
    parameter int IDXW   = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [NBANKS*WIDTH-1:0] BANK_IN,
    output logic [WIDTH-1:0]        OUT_DATA,
    output logic [IDXW-1:0]         OUT_IDX,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    BUSY,
    output logic                    DONE
);
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;
    state_t                         state_q, state_d;
    logic [IDXW-1:0]                idx_q, idx_d;
    logic [NBANKS-1:0][WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]               out_data_q, out_data_d;
    logic [IDXW-1:0]                out_idx_q, out_idx_d;
    logic                           out_valid_q, out_valid_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic                           advance;
    logic                           changed;
`ifdef CHANGE_FILTER_EN
    logic [NBANKS-1:0][WIDTH-1:0]   hist_q, hist_d;
`endif
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
`ifdef CHANGE_FILTER_EN
        hist_d   = hist_q;
`endif
        // A presented bank advances on a handshake; a suppressed (unchanged) bank advances unconditionally.
        advance  = (state_q == S_SEND) && (out_valid_q ? OUT_READY : 1'b1);
        if (state_q == S_IDLE && START) begin
            shadow_d = BANK_IN;
            idx_d    = '0;
            state_d  = S_SEND;
        end
        if (advance) begin
`ifdef CHANGE_FILTER_EN
            if (out_valid_q)
                hist_d[idx_q] = shadow_q[idx_q];
`endif
            if (idx_q == IDXW'(NBANKS - 1)) begin
                idx_d   = '0;
                state_d = S_DONE;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        if (state_q == S_DONE)
            state_d = S_IDLE;
`ifdef CHANGE_FILTER_EN
        changed = shadow_d[idx_d] != hist_d[idx_d];
`else
        changed = 1'b1;
`endif
        // Outputs are registered copies of what the next state presents.
        out_valid_d = (state_d == S_SEND) && changed;
        out_data_d  = (state_d == S_SEND) ? shadow_d[idx_d] : '0;
        out_idx_d   = (state_d == S_SEND) ? idx_d : '0;
        busy_d      = state_d != S_IDLE;
        done_d      = state_d == S_DONE;
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            shadow_q    <= '0;
`ifdef CHANGE_FILTER_EN
            hist_q      <= '0;
`endif
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
`ifdef CHANGE_FILTER_EN
            hist_q      <= hist_d;
`endif
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
    assign OUT_DATA  = out_data_q;
    assign OUT_IDX   = out_idx_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
endmodule

// File: tb/tb_bank_readout_serializer.sv
// tb_bank_readout_serializer: randomized self-checking bench for bank_readout_serializer.
module tb_bank_readout_serializer;
    localparam int W  = 5;
    localparam int N  = 5;
    localparam int IW = 3;
`ifdef CHANGE_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif
    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic           START = 1'b0;
    logic           OUT_READY = 1'b0;
    logic [N*W-1:0] BANK_IN = '0;
    logic [W-1:0]   OUT_DATA;
    logic [IW-1:0]  OUT_IDX;
    logic           OUT_VALID, BUSY, DONE;
    int             total = 0;
    int             bad = 0;
    logic [W-1:0]   hist [N];
    always #5 CLK = ~CLK;
    bank_readout_serializer #(.WIDTH(W), .NBANKS(N), .IDXW(IW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BANK_IN(BANK_IN),
        .OUT_DATA(OUT_DATA), .OUT_IDX(OUT_IDX), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .BUSY(BUSY), .DONE(DONE)
    );
    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b1; START = 1'b0; OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        foreach (hist[i]) hist[i] = '0;
    endtask
    // One readout: mode 0 = ready always high, 1 = three stall cycles on bank 1 with BANK_IN forced to all ones,
    // 2 = random ready. exp_done < 0 skips the exact DONE-cycle check. Model: a bank pointer walking the snapshot.
    task automatic run(input logic [N*W-1:0] banks, input int mode, input int exp_done, output int ntx);
        int p = 0, stall = 0, c;
        bit fin = 1'b0, ev;
        logic [W-1:0] b;
        ntx = 0;
        BANK_IN = banks; START = 1'b1; OUT_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        for (c = 1; c <= 100 && !fin; c++) begin
            if (p < N) begin
                b  = banks[p*W +: W];
                ev = !FILT || b != hist[p];
                total++;
                if (OUT_VALID !== ev || BUSY !== 1'b1 || DONE !== 1'b0) begin
                    bad++;
                    $display("FAIL send_ctl cyc=%0d bank=%0d got v/b/d=%b%b%b exp=%b10", c, p, OUT_VALID, BUSY, DONE, ev);
                end
                if (ev) begin
                    total++;
                    if (OUT_IDX !== p[IW-1:0] || OUT_DATA !== b) begin
                        bad++;
                        $display("FAIL send_data cyc=%0d got idx=%0d data=%h exp idx=%0d data=%h", c, OUT_IDX, OUT_DATA, p, b);
                    end
                end
                OUT_READY = mode == 0 ? 1'b1 : mode == 1 ? !(p == 1 && stall < 3) : 1'($urandom_range(0, 1));
                if (mode == 1 && p == 1 && !OUT_READY) stall++;
                START   = $urandom_range(0, 3) == 0;
                BANK_IN = mode == 1 ? '1 : (N*W)'($urandom);
                if (!ev) p++;
                else if (OUT_READY) begin
                    hist[p] = b;
                    ntx++;
                    p++;
                end
            end else begin
                total++;
                if (DONE !== 1'b1 || BUSY !== 1'b1 || OUT_VALID !== 1'b0) begin
                    bad++;
                    $display("FAIL done_pulse cyc=%0d got d/b/v=%b%b%b exp=110", c, DONE, BUSY, OUT_VALID);
                end
                if (exp_done >= 0) begin
                    total++;
                    if (c !== exp_done) begin
                        bad++;
                        $display("FAIL done_cycle got=%0d exp=%0d", c, exp_done);
                    end
                end
                START = 1'b1;
                fin = 1'b1;
            end
            @(negedge CLK);
        end
        if (!fin) begin
            bad++; total++;
            $display("FAIL timeout got=no_done exp=done_within_100");
        end
        START = 1'b0;
        OUT_READY = 1'($urandom_range(0, 1));
        for (int k = 0; k < 2; k++) begin
            total++;
            if (DONE !== 1'b0 || BUSY !== 1'b0 || OUT_VALID !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_done step=%0d got d/b/v=%b%b%b exp=000", k, DONE, BUSY, OUT_VALID);
            end
            @(negedge CLK);
        end
    endtask
    task automatic test_reset();
        apply_reset();
        @(negedge CLK);
        total++;
        if ({OUT_VALID, BUSY, DONE} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl got v/b/d=%b%b%b exp=000", OUT_VALID, BUSY, DONE);
        end
        total++;
        if (OUT_DATA !== '0 || OUT_IDX !== '0) begin
            bad++;
            $display("FAIL reset_data got data=%h idx=%0d exp=0/0", OUT_DATA, OUT_IDX);
        end
    endtask
    task automatic test_basic();
        int n;
        apply_reset();
        run({5'h10, 5'h08, 5'h04, 5'h02, 5'h01}, 0, N + 1, n);
        total++;
        if (n !== N) begin
            bad++;
            $display("FAIL basic_count got=%0d exp=%0d", n, N);
        end
    endtask
    task automatic test_backpressure();
        int n;
        apply_reset();
        run({5'h10, 5'h08, 5'h04, 5'h02, 5'h01}, 1, N + 4, n);
        total++;
        if (n !== N) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=%0d", n, N);
        end
    endtask
    task automatic test_reset_mid();
        logic [N*W-1:0] banks;
        int n;
        apply_reset();
        banks = (N*W)'($urandom);
        for (int i = 0; i < N; i++) banks[i*W] = 1'b1;
        BANK_IN = banks; START = 1'b1; OUT_READY = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            START = 1'b0;
        end
        total++;
        if (OUT_VALID !== 1'b1 || OUT_IDX !== 3'd2) begin
            bad++;
            $display("FAIL mid_pre got v=%b idx=%0d exp v=1 idx=2", OUT_VALID, OUT_IDX);
        end
        #2 RST = 1'b1;
        #1;
        total++;
        if ({OUT_VALID, BUSY, DONE} !== 3'b000) begin
            bad++;
            $display("FAIL mid_async got v/b/d=%b%b%b exp=000", OUT_VALID, BUSY, DONE);
        end
        @(negedge CLK);
        RST = 1'b0;
        foreach (hist[i]) hist[i] = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            total++;
            if (OUT_VALID !== 1'b0 || BUSY !== 1'b0) begin
                bad++;
                $display("FAIL mid_idle step=%0d got v=%b b=%b exp=0/0", k, OUT_VALID, BUSY);
            end
        end
        run(banks, 0, N + 1, n);
    endtask
    task automatic test_filter();
        int n;
        logic [N*W-1:0] basic;
        basic = {5'h10, 5'h08, 5'h04, 5'h02, 5'h01};
        apply_reset();
        run(basic, 0, N + 1, n);
        basic[3*W +: W] = 5'h0A;
        run(basic, 0, N + 1, n);
        total++;
        if (n !== (FILT ? 1 : N)) begin
            bad++;
            $display("FAIL filter_count got=%0d exp=%0d", n, FILT ? 1 : N);
        end
        apply_reset();
        run('0, 0, N + 1, n);
        total++;
        if (n !== (FILT ? 0 : N)) begin
            bad++;
            $display("FAIL zero_count got=%0d exp=%0d", n, FILT ? 0 : N);
        end
    endtask
    task automatic test_random();
        logic [N*W-1:0] banks = '0;
        int n;
        apply_reset();
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 1) == 1) banks[i*W +: W] = W'($urandom);
            run(banks, 2, -1, n);
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_filter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
